// File: rtl/seg_scan_pkg.sv
// Shared constants for the 7-segment scan capture block.
// Glyph table and legality check are in the active-low gfedcba order used on the CX bus.
package seg_scan_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index n holds the glyph that displays hex digit n.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic seg_is_legal(input logic [6:0] code);
    logic hit;
    hit = 1'b0;
    for (int n = 0; n < 16; n++) begin
      if (code == SEG_GLYPH[n]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational decode of an active-low segment code to a hex nibble.
// Codes outside the glyph table decode to 0 with legal deasserted.
module seg7_to_hex
  import seg_scan_pkg::*;
(
  input  logic [6:0] code,
  output logic [3:0] hex,
  output logic       legal
);

  always_comb begin
    hex = 4'h0;
    for (int n = 0; n < 16; n++) begin
      if (code == SEG_GLYPH[n]) hex = 4'(n);
    end
  end

  assign legal = seg_is_legal(code);

endmodule

// File: rtl/seg_scan_capture.sv
// Captures a multiplexed 7-segment scan back into per-digit registers with
// glitch filtering, glyph decode, staleness detection and a frame-complete pulse.
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int STABLE_CNT  = 3,
  parameter int TIMEOUT_CYC = 1 << 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              CX,
  input  logic [7:0]              An,
  output logic [NUM_DIGITS*7-1:0] digit_seg,
  output logic [NUM_DIGITS*4-1:0] digit_hex,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_bad,
  output logic [NUM_DIGITS-1:0]   digit_stale,
  output logic                    frame_done
);

  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [6:0]            cx_s1, cx_s2, cx_prev;
  logic [7:0]            an_s1, an_s2, an_prev;
  logic [CW-1:0]         cnt_reg, cnt_next;
  logic                  fire, changed, sel_ok;
  logic [NUM_DIGITS-1:0] sel, commit, mask_reg, mask_with;
  logic [3:0]            dec_hex;
  logic                  dec_legal;
  logic                  frame_done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx_s1   <= SEG_BLANK;
      cx_s2   <= SEG_BLANK;
      cx_prev <= SEG_BLANK;
      an_s1   <= 8'hFF;
      an_s2   <= 8'hFF;
      an_prev <= 8'hFF;
      cnt_reg <= '0;
    end else begin
      cx_s1   <= CX;
      cx_s2   <= cx_s1;
      cx_prev <= cx_s2;
      an_s1   <= An;
      an_s2   <= an_s1;
      an_prev <= an_s2;
      cnt_reg <= cnt_next;
    end
  end

  // Legal select requires exactly one low anode and all unused anodes high.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
    assign sel[gi] = (an_s2 == ~(8'd1 << gi));
  end

  assign sel_ok  = |sel;
  assign changed = ({an_s2, cx_s2} != {an_prev, cx_prev});

  // The counter saturates at STABLE_CNT, so the commit fires only on the
  // transition into that value: one commit per dwell.
  always_comb begin
    cnt_next = cnt_reg;
    fire     = 1'b0;
    if (!sel_ok) begin
      cnt_next = '0;
    end else if (changed) begin
      cnt_next = CW'(1);
      fire     = (STABLE_CNT == 1);
    end else if (cnt_reg != CW'(STABLE_CNT)) begin
      cnt_next = cnt_reg + CW'(1);
      fire     = (cnt_reg == CW'(STABLE_CNT - 1));
    end
  end

  assign commit = fire ? sel : '0;

  seg7_to_hex u_dec (
    .code  (cx_s2),
    .hex   (dec_hex),
    .legal (dec_legal)
  );

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [TW-1:0] timer_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        digit_seg[7*gi +: 7] <= SEG_BLANK;
        digit_hex[4*gi +: 4] <= 4'h0;
        digit_bad[gi]        <= 1'b0;
        digit_valid[gi]      <= 1'b0;
        digit_stale[gi]      <= 1'b0;
        timer_reg            <= '0;
      end else if (commit[gi]) begin
        digit_seg[7*gi +: 7] <= cx_s2;
        digit_hex[4*gi +: 4] <= dec_hex;
        digit_bad[gi]        <= ~dec_legal;
        digit_valid[gi]      <= 1'b1;
        digit_stale[gi]      <= 1'b0;
        timer_reg            <= '0;
      end else if (timer_reg != TW'(TIMEOUT_CYC)) begin
        timer_reg <= timer_reg + TW'(1);
        if (timer_reg == TW'(TIMEOUT_CYC - 1)) begin
          digit_stale[gi] <= 1'b1;
          digit_valid[gi] <= 1'b0;
        end
      end
    end
  end

  // Mask clears as the pulse is issued; commits during the pulse land in the fresh mask.
  assign mask_with = mask_reg | commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_reg       <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= &mask_with;
      mask_reg       <= (&mask_with) ? '0 : mask_with;
    end
  end

  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed self-checking bench for seg_scan_capture with a short stale timeout.
module tb_seg_scan_capture;

  localparam int ND = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [6:0]      cx;
  logic [7:0]      an;
  logic [ND*7-1:0] digit_seg;
  logic [ND*4-1:0] digit_hex;
  logic [ND-1:0]   digit_valid, digit_bad, digit_stale;
  logic            frame_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg_scan_capture #(
    .NUM_DIGITS  (ND),
    .STABLE_CNT  (3),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .CX          (cx),
    .An          (an),
    .digit_seg   (digit_seg),
    .digit_hex   (digit_hex),
    .digit_valid (digit_valid),
    .digit_bad   (digit_bad),
    .digit_stale (digit_stale),
    .frame_done  (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  logic [6:0]      glyph [4];
  logic [ND*7-1:0] seg_saved;
  logic [ND*4-1:0] hex_saved;
  int              pulses;

  initial begin
    glyph[0] = 7'h79; glyph[1] = 7'h24; glyph[2] = 7'h30; glyph[3] = 7'h19;
    rst_n = 1'b0;
    cx    = 7'h7F;
    an    = 8'hFE;

    // Reset held while the bus toggles: nothing may leave reset state.
    for (int c = 0; c < 3; c++) begin
      cx = (c % 2 == 0) ? 7'h30 : 7'h24;
      tick(1);
      chk("rst_seg", 32'(digit_seg), 32'({ND{7'h7F}}));
      chk("rst_flags", {16'h0, digit_valid, digit_bad, digit_stale, 3'b0, frame_done}, 32'h0);
    end
    chk("rst_hex", 32'(digit_hex), 32'h0);
    cx = 7'h7F;
    an = 8'hFF;
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Single digit: visible exactly 5 cycles after the pins change.
    an = 8'hFE;
    cx = 7'h30;
    tick(4);
    chk("single_valid_early", 32'(digit_valid[0]), 32'h0);
    tick(1);
    chk("single_valid", 32'(digit_valid[0]), 32'h1);
    chk("single_hex", 32'(digit_hex[3:0]), 32'h3);
    chk("single_bad", 32'(digit_bad[0]), 32'h0);
    chk("single_seg", 32'(digit_seg[6:0]), 32'h30);
    tick(1);

    // Glitch: a 2-cycle '2' must never be committed on digit 1.
    an = 8'hFD;
    cx = 7'h24;
    for (int c = 0; c < 2; c++) begin
      tick(1);
      chk("glitch_no2", 32'(digit_seg[13:7] == 7'h24), 32'h0);
    end
    cx = 7'h30;
    for (int c = 0; c < 6; c++) begin
      tick(1);
      chk("glitch_no2", 32'(digit_seg[13:7] == 7'h24), 32'h0);
    end
    chk("glitch_hex", 32'(digit_hex[7:4]), 32'h3);
    chk("glitch_valid", 32'(digit_valid[1]), 32'h1);

    // Full scans: one frame pulse per completed scan, during digit 3's dwell.
    an = 8'hFF;
    cx = 7'h7F;
    do_reset();
    tick(2);
    pulses = 0;
    for (int s = 0; s < 2; s++) begin
      for (int d = 0; d < 4; d++) begin
        an = ~(8'd1 << d);
        cx = glyph[d];
        for (int c = 0; c < 8; c++) begin
          tick(1);
          if (frame_done) pulses++;
        end
        if (d == 2) chk("scan_pulses_before_d3", 32'(pulses), 32'(s));
      end
      chk("scan_pulses", 32'(pulses), 32'(s + 1));
    end
    chk("scan_hex", 32'(digit_hex), 32'h4321);
    chk("scan_valid", 32'(digit_valid), 32'hF);
    chk("scan_bad", 32'(digit_bad), 32'h0);

    // Illegal glyph on digit 2, then a two-anode select that must be ignored.
    an = 8'hFB;
    cx = 7'h55;
    tick(8);
    chk("illegal_seg", 32'(digit_seg[20:14]), 32'h55);
    chk("illegal_hex", 32'(digit_hex[11:8]), 32'h0);
    chk("illegal_bad", 32'(digit_bad[2]), 32'h1);
    chk("illegal_valid", 32'(digit_valid[2]), 32'h1);
    seg_saved = digit_seg;
    hex_saved = digit_hex;
    an = 8'hFC;
    cx = 7'h79;
    tick(8);
    chk("twolow_seg", 32'(digit_seg), 32'(seg_saved));
    chk("twolow_hex", 32'(digit_hex), 32'(hex_saved));

    // Stale: 64 cycles after the commit with no refresh.
    an = 8'hFF;
    cx = 7'h7F;
    do_reset();
    an = 8'hF7;
    cx = 7'h19;
    tick(5);
    chk("stale_commit_valid", 32'(digit_valid[3]), 32'h1);
    chk("stale_commit_stale", 32'(digit_stale[3]), 32'h0);
    an = 8'hFF;
    cx = 7'h7F;
    tick(63);
    chk("stale_before", 32'(digit_stale[3]), 32'h0);
    tick(1);
    chk("stale_set", 32'(digit_stale[3]), 32'h1);
    chk("stale_valid", 32'(digit_valid[3]), 32'h0);
    chk("stale_seg_kept", 32'(digit_seg[27:21]), 32'h19);
    chk("stale_hex_kept", 32'(digit_hex[15:12]), 32'h4);
    an = 8'hF7;
    cx = 7'h19;
    tick(4);
    chk("recommit_early", 32'(digit_stale[3]), 32'h1);
    tick(1);
    chk("recommit_stale", 32'(digit_stale[3]), 32'h0);
    chk("recommit_valid", 32'(digit_valid[3]), 32'h1);

    // Reset mid-dwell: pre-reset samples must not shorten the post-reset dwell.
    an = 8'hFF;
    cx = 7'h7F;
    do_reset();
    tick(2);
    an = 8'hFB;
    cx = 7'h24;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    chk("midrst_valid", 32'(digit_valid), 32'h0);
    rst_n = 1'b1;
    tick(4);
    chk("midrst_no_early", 32'(digit_valid[2]), 32'h0);
    tick(1);
    chk("midrst_commit", 32'(digit_valid[2]), 32'h1);
    chk("midrst_seg", 32'(digit_seg[20:14]), 32'h24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
